// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: load-use interlock, mul/div
// occupancy of EX, data-memory wait states and taken-branch flushes.
module hazard_ctrl #(
    parameter int MULDIV_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        idex_mem_read,
    input  logic [4:0]  idex_rd,
    input  logic [4:0]  ifid_rs1,
    input  logic [4:0]  ifid_rs2,
    input  logic        ifid_uses_rs2,
    input  logic        idex_muldiv,
    input  logic        ex_branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        idex_stall,
    output logic        exmem_stall,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        pc_redirect,
    output logic        muldiv_busy,
    output logic        muldiv_done,
    output logic [31:0] stall_count
);
    localparam int CW = $clog2(MULDIV_LAT);

    typedef enum logic {RUN, MULDIV} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    stall_count_q;
    logic           mem_stall, lu_hz, md_stall;

    assign mem_stall = dmem_req & ~dmem_ready;
    assign lu_hz     = idex_mem_read & (idex_rd != 5'd0) &
                       ((idex_rd == ifid_rs1) | (ifid_uses_rs2 & (idex_rd == ifid_rs2)));
    assign md_stall  = ((state_q == RUN) & idex_muldiv) |
                       ((state_q == MULDIV) & (cnt_q != '0));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        pc_redirect = 1'b0;
        muldiv_done = 1'b0;
        muldiv_busy = (state_q == MULDIV);

        // A taken branch alongside a mul/div is ignored: md_stall outranks it.
        if (mem_stall) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
        end else if (md_stall) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_flush = 1'b1;
        end else if (ex_branch_taken) begin
            pc_redirect = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (lu_hz) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_flush  = 1'b1;
        end

        // The occupancy counter freezes while memory holds the pipeline.
        if (!mem_stall) begin
            case (state_q)
                RUN: if (idex_muldiv) begin
                    state_d = MULDIV;
                    cnt_d   = CW'(MULDIV_LAT - 2);
                end
                MULDIV: if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d     = RUN;
                    muldiv_done = 1'b1;
                end
                default: state_d = RUN;
            endcase
        end

        if (rst) begin
            pc_stall    = 1'b0;
            ifid_stall  = 1'b0;
            idex_stall  = 1'b0;
            exmem_stall = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
            memwb_flush = 1'b0;
            pc_redirect = 1'b0;
            muldiv_done = 1'b0;
            muldiv_busy = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (pc_stall && (stall_count_q != 32'hFFFF_FFFF))
                stall_count_q <= stall_count_q + 32'd1;
        end
    end

    assign stall_count = stall_count_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        idex_mem_read, ifid_uses_rs2, idex_muldiv, ex_branch_taken;
    logic        dmem_req, dmem_ready;
    logic [4:0]  idex_rd, ifid_rs1, ifid_rs2;
    logic        pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic        pc_redirect, muldiv_busy, muldiv_done;
    logic [31:0] stall_count;

    localparam logic [10:0] PCS = 11'h400, IFS = 11'h200, IDS = 11'h100, EXS = 11'h080;
    localparam logic [10:0] IFF = 11'h040, IDF = 11'h020, EXF = 11'h010, MWF = 11'h008;
    localparam logic [10:0] RED = 11'h004, BSY = 11'h002, DON = 11'h001;
    localparam logic [10:0] LU  = PCS | IFS | IDF;
    localparam logic [10:0] MD  = PCS | IFS | IDS | EXF;
    localparam logic [10:0] MEM = PCS | IFS | IDS | EXS | MWF;
    localparam logic [10:0] BR  = RED | IFF | IDF;

    typedef struct packed {
        logic [10:0] o;
        logic [31:0] c;
    } exp_t;

    exp_t        expq[$];
    string       nameq[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_cnt = 32'd0;

    hazard_ctrl #(.MULDIV_LAT(4)) dut (
        .clk(clk), .rst(rst),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_uses_rs2(ifid_uses_rs2),
        .idex_muldiv(idex_muldiv), .ex_branch_taken(ex_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
        .exmem_stall(exmem_stall), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .pc_redirect(pc_redirect),
        .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Monitor: every cycle the controller presents a full output set.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t  e;
            string n;
            logic [10:0] act;
            e   = expq.pop_front();
            n   = nameq.pop_front();
            act = {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush,
                   exmem_flush, memwb_flush, pc_redirect, muldiv_busy, muldiv_done};
            checks++;
            if (act !== e.o) begin
                errors++;
                $display("FAIL %s outputs: got %b expected %b", n, act, e.o);
            end
            checks++;
            if (stall_count !== e.c) begin
                errors++;
                $display("FAIL %s stall_count: got %h expected %h", n, stall_count, e.c);
            end
        end
    end

    // Push the expectation for the inputs currently applied, then advance one cycle.
    task automatic chk(input logic [10:0] exp_o, input string nm);
        logic r;
        r = rst;
        if (r) exp_cnt = 32'd0;
        expq.push_back('{o: exp_o, c: exp_cnt});
        nameq.push_back(nm);
        @(posedge clk);
        #1;
        if (!r && exp_o[10] && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic clr();
        idex_mem_read = 0; idex_rd = 0; ifid_rs1 = 0; ifid_rs2 = 0; ifid_uses_rs2 = 0;
        idex_muldiv = 0; ex_branch_taken = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; clr();
        @(posedge clk); #1;
        // Reset masks all outputs, even with hazards on the inputs
        idex_muldiv = 1; dmem_req = 1;
        chk(0, "reset_md_mem");
        idex_muldiv = 0; dmem_req = 0; ex_branch_taken = 1;
        chk(0, "reset_br");
        rst = 0; clr();
        chk(0, "idle0");

        // Load-use
        idex_mem_read = 1; idex_rd = 5; ifid_rs1 = 5;
        chk(LU, "lu_rs1");
        clr();
        chk(0, "lu_after");
        idex_mem_read = 1; idex_rd = 0; ifid_rs1 = 0;
        chk(0, "lu_x0");
        idex_rd = 7; ifid_rs1 = 1; ifid_rs2 = 7; ifid_uses_rs2 = 0;
        chk(0, "lu_rs2_unused");
        ifid_uses_rs2 = 1;
        chk(LU, "lu_rs2");
        clr();

        // Mul/div held: 3 stalls, done in cycle 4
        idex_muldiv = 1;
        chk(MD, "md1");
        chk(MD | BSY, "md2");
        chk(MD | BSY, "md3");
        chk(BSY | DON, "md4_done");
        idex_muldiv = 0;
        chk(0, "md_run");

        // Memory wait while cnt=1
        idex_muldiv = 1;
        chk(MD, "mw1");
        chk(MD | BSY, "mw2");
        dmem_req = 1; dmem_ready = 0;
        chk(MEM | BSY, "mw_wait1");
        chk(MEM | BSY, "mw_wait2");
        dmem_ready = 1;
        chk(MD | BSY, "mw_cnt1");
        dmem_req = 0; dmem_ready = 0;
        chk(BSY | DON, "mw_done");
        idex_muldiv = 0;
        chk(0, "mw_run");

        // Branch beats load-use, loses to mem_stall
        idex_mem_read = 1; idex_rd = 5; ifid_rs1 = 5; ex_branch_taken = 1;
        chk(BR, "br_over_lu");
        dmem_req = 1;
        chk(MEM, "br_mem_stall");
        dmem_req = 0;
        chk(BR, "br_after_mem");
        clr();

        // Branch with mul/div: mul/div wins
        ex_branch_taken = 1; idex_muldiv = 1;
        chk(MD, "br_md");
        ex_branch_taken = 0;
        chk(MD | BSY, "br_md2");
        chk(MD | BSY, "br_md3");
        chk(BSY | DON, "br_md_done");
        idex_muldiv = 0;
        chk(0, "br_md_run");

        // Reset while MULDIV with cnt=2
        idex_muldiv = 1;
        chk(MD, "rm1");
        rst = 1;
        chk(0, "rm_reset");
        rst = 0;
        chk(MD, "rm_run_again");
        chk(MD | BSY, "rm2");
        chk(MD | BSY, "rm3");
        chk(BSY | DON, "rm_done");
        idex_muldiv = 0;
        chk(0, "rm_idle");

        // Saturation from a preloaded near-max count
        force dut.stall_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_count_q;
        exp_cnt = 32'hFFFF_FFFE;
        idex_mem_read = 1; idex_rd = 3; ifid_rs1 = 3;
        chk(LU, "sat1");
        chk(LU, "sat2");
        chk(LU, "sat3");
        clr();
        chk(0, "sat_hold");

        repeat (2) @(negedge clk);
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
